haz_resolver_param: RTL and testbench

HAZ_RESOLVER_PARAM -- requirements
Module: haz_resolver_param

---
 rtl/haz_resolver_param.sv | 103 ++++++++++
 tb/tb_haz_resolver_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/haz_resolver_param.sv
// haz_resolver_param: pipeline hazard resolver (load-use/structural stalls, branch flush, forwarding)
module haz_resolver_param #(
   parameter int AW        = 5,
   parameter int LOAD_LAT  = 2,
   parameter int FLUSH_CYC = 2,
   parameter int MAX_STALL = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic [AW-1:0]                  id_rs1,
   input  logic [AW-1:0]                  id_rs2,
   input  logic                           ex_wr_en,
   input  logic                           ex_is_load,
   input  logic [AW-1:0]                  ex_rd,
   input  logic                           mem_wr_en,
   input  logic [AW-1:0]                  mem_rd,
   input  logic                           mem_busy,
   input  logic                           br_resolve,
   input  logic                           br_mispredict,
   input  logic                           err_clr,
   output logic [1:0]                     fwd_a,
   output logic [1:0]                     fwd_b,
   output logic                           pc_freeze,
   output logic                           do_flush,
   output logic                           resolved,
   output logic [2:0]                     state,
   output logic [$clog2(MAX_STALL+1)-1:0] stall_cnt,
   output logic                           timeout_err
);
   localparam logic [2:0] NORMAL       = 3'd0;
   localparam logic [2:0] DATA_STALL   = 3'd1;
   localparam logic [2:0] STRUCT_STALL = 3'd2;
   localparam logic [2:0] FLUSH        = 3'd3;
   localparam int CMAX = LOAD_LAT > FLUSH_CYC ? LOAD_LAT : FLUSH_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int SW   = $clog2(MAX_STALL + 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          timeout_err_q, timeout_err_d;
   logic          mispredict, load_use, stalling, timeout;

   always_comb begin
      mispredict    = br_resolve & br_mispredict;
      load_use      = id_valid & ex_wr_en & ex_is_load & (ex_rd != '0) & (ex_rd == id_rs1 | ex_rd == id_rs2);
      stalling      = state_q == DATA_STALL || state_q == STRUCT_STALL;
      timeout       = stalling & (stall_cnt_q == SW'(MAX_STALL)) & ~mispredict;
      stall_cnt_d   = !stalling ? '0 : stall_cnt_q == SW'(MAX_STALL) ? stall_cnt_q : stall_cnt_q + 1'b1;
      timeout_err_d = timeout | (timeout_err_q & ~err_clr);
      state_d       = NORMAL;
      cnt_d         = '0;
      if (mispredict) begin
         state_d = FLUSH;
         cnt_d   = CW'(FLUSH_CYC - 1);
      end else if (!timeout) begin
         case (state_q)
            NORMAL: begin
               state_d = load_use ? DATA_STALL : mem_busy ? STRUCT_STALL : NORMAL;
               cnt_d   = load_use ? CW'(LOAD_LAT - 1) : '0;
            end
            DATA_STALL: begin
               state_d = cnt_q != '0 ? DATA_STALL : mem_busy ? STRUCT_STALL : NORMAL;
               cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : '0;
            end
            STRUCT_STALL: state_d = mem_busy ? STRUCT_STALL : NORMAL;
            FLUSH: begin
               state_d = cnt_q != '0 ? FLUSH : NORMAL;
               cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : '0;
            end
            default: state_d = NORMAL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= NORMAL;
         cnt_q         <= '0;
         stall_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Load results are not yet available in EX, so they are never forwarded from there
   assign fwd_a = (ex_wr_en & ~ex_is_load & ex_rd != '0 & ex_rd == id_rs1) ? 2'b01 :
                  (mem_wr_en & mem_rd != '0 & mem_rd == id_rs1) ? 2'b10 : 2'b00;
   assign fwd_b = (ex_wr_en & ~ex_is_load & ex_rd != '0 & ex_rd == id_rs2) ? 2'b01 :
                  (mem_wr_en & mem_rd != '0 & mem_rd == id_rs2) ? 2'b10 : 2'b00;

   assign state       = state_q;
   assign resolved    = state_q == NORMAL;
   assign pc_freeze   = state_q == DATA_STALL || state_q == STRUCT_STALL || state_q == FLUSH;
   assign do_flush    = state_q == FLUSH;
   assign stall_cnt   = stall_cnt_q;
   assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_haz_resolver_param.sv
// tb_haz_resolver_param: directed + random checks of haz_resolver_param against a cycle model
module tb_haz_resolver_param;
   localparam int AW = 5, LL = 2, FC = 2, MS = 8;

   logic clk = 0, rst_n = 0;
   logic id_valid, ex_wr_en, ex_is_load, mem_wr_en, mem_busy, br_resolve, br_mispredict, err_clr;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
   logic [1:0] fwd_a, fwd_b;
   logic pc_freeze, do_flush, resolved, timeout_err;
   logic [2:0] state;
   logic [3:0] stall_cnt;
   int total = 0, bad = 0;
   int ms, mrem, mstall, merr;

   haz_resolver_param #(.AW(AW), .LOAD_LAT(LL), .FLUSH_CYC(FC), .MAX_STALL(MS)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_wr_en(mem_wr_en),
      .mem_rd(mem_rd), .mem_busy(mem_busy), .br_resolve(br_resolve), .br_mispredict(br_mispredict),
      .err_clr(err_clr), .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_freeze(pc_freeze), .do_flush(do_flush),
      .resolved(resolved), .state(state), .stall_cnt(stall_cnt), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int fwd_ref(input logic [AW-1:0] rs);
      if (rs == 0) return 0;
      if (ex_wr_en && !ex_is_load && ex_rd == rs) return 1;
      if (mem_wr_en && mem_rd == rs) return 2;
      return 0;
   endfunction

   task automatic idle();
      id_valid = 0; ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 0; mem_busy = 0;
      br_resolve = 0; br_mispredict = 0; err_clr = 0;
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
   endtask

   task automatic model_reset();
      ms = 0; mrem = 0; mstall = 0; merr = 0;
   endtask

   task automatic check_all();
      chk("state", state, ms);
      chk("resolved", resolved, ms == 0);
      chk("pc_freeze", pc_freeze, ms != 0);
      chk("do_flush", do_flush, ms == 3);
      chk("stall_cnt", stall_cnt, mstall);
      chk("timeout_err", timeout_err, merr);
      chk("fwd_a", fwd_a, fwd_ref(id_rs1));
      chk("fwd_b", fwd_b, fwd_ref(id_rs2));
   endtask

   // Called at a negedge with inputs settled; checks, then advances one clock and the model
   task automatic tick();
      int ns, nrem, nstall, to;
      bit mp, lu, st;
      #1 check_all();
      mp = br_resolve && br_mispredict;
      lu = id_valid && ex_wr_en && ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      st = ms == 1 || ms == 2;
      to = 0; ns = 0; nrem = 0;
      if (mp) begin ns = 3; nrem = FC; end
      else if (st && mstall == MS) to = 1;
      else if (ms == 0) begin ns = lu ? 1 : mem_busy ? 2 : 0; nrem = lu ? LL : 0; end
      else if (ms == 1) begin
         if (mrem > 1) begin ns = 1; nrem = mrem - 1; end else ns = mem_busy ? 2 : 0;
      end else if (ms == 2) ns = mem_busy ? 2 : 0;
      else if (ms == 3 && mrem > 1) begin ns = 3; nrem = mrem - 1; end
      nstall = st ? (mstall < MS ? mstall + 1 : MS) : 0;
      merr = to || (merr && !err_clr);
      @(posedge clk);
      ms = ns; mrem = nrem; mstall = nstall;
      @(negedge clk);
   endtask

   initial begin
      int n, mx;
      idle();
      model_reset();
      #12;
      check_all();
      @(negedge clk) rst_n = 1;
      tick();

      // load-use on rs2
      id_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 1; id_rs2 = 3;
      tick();
      idle();
      n = 0;
      for (int i = 0; i < 5; i++) begin
         n += pc_freeze;
         tick();
      end
      chk("loaduse_freeze_cycles", n, 2);
      chk("loaduse_resolved", resolved, 1);

      // forwarding priority
      ex_wr_en = 1; mem_wr_en = 1; ex_rd = 7; mem_rd = 7; id_rs1 = 7;
      #1 chk("fwd_ex", fwd_a, 2'b01);
      ex_rd = 0;
      #1 chk("fwd_mem", fwd_a, 2'b10);
      id_rs1 = 0;
      #1 chk("fwd_r0", fwd_a, 2'b00);
      ex_rd = 9; id_rs2 = 9; ex_is_load = 1; mem_rd = 4;
      #1 chk("fwd_noload", fwd_b, 2'b00);
      idle();
      tick();

      // flush restart
      br_resolve = 1; br_mispredict = 1;
      tick();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         n += do_flush;
         br_resolve = i == 0; br_mispredict = i == 0;
         tick();
      end
      chk("flush_restart_cycles", n, 3);

      // load-use together with mispredict
      id_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 5;
      br_resolve = 1; br_mispredict = 1;
      tick();
      chk("simul_flush", state, 3);
      idle();
      for (int i = 0; i < 3; i++) tick();

      // stall timeout
      mem_busy = 1; mx = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (stall_cnt > mx) mx = stall_cnt;
      end
      chk("timeout_max_cnt", mx, MS);
      chk("timeout_set", timeout_err, 1);
      mem_busy = 0;
      for (int i = 0; i < 3; i++) tick();
      chk("timeout_sticky", timeout_err, 1);
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("timeout_cleared", timeout_err, 0);
      tick();

      // async reset mid-flush
      br_resolve = 1; br_mispredict = 1;
      tick();
      idle();
      #2 rst_n = 0;
      #1 chk("async_flush", do_flush, 0);
      chk("async_state", state, 0);
      model_reset();
      @(negedge clk) rst_n = 1;
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         id_valid = $urandom_range(0, 3) != 0;
         id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
         ex_rd = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
         ex_wr_en = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
         mem_wr_en = $urandom_range(0, 1);
         mem_busy = (i % 100) > 70 ? 1'b1 : $urandom_range(0, 2) == 0;
         br_resolve = $urandom_range(0, 7) == 0; br_mispredict = $urandom_range(0, 1);
         err_clr = $urandom_range(0, 15) == 0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
